// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad bit map, idle row drive and small
// helper functions used by the keypad scanner.
package calc_pkg;

    // Bit positions in key_out / key_pulse (bit = row_idx*4 + col_idx)
    localparam int unsigned KEY_1   = 0;
    localparam int unsigned KEY_2   = 1;
    localparam int unsigned KEY_3   = 2;
    localparam int unsigned KEY_ADD = 3;
    localparam int unsigned KEY_4   = 4;
    localparam int unsigned KEY_5   = 5;
    localparam int unsigned KEY_6   = 6;
    localparam int unsigned KEY_SUB = 7;
    localparam int unsigned KEY_7   = 8;
    localparam int unsigned KEY_8   = 9;
    localparam int unsigned KEY_9   = 10;
    localparam int unsigned KEY_MUL = 11;
    localparam int unsigned KEY_0   = 12;
    localparam int unsigned KEY_CLR = 13;
    localparam int unsigned KEY_EQ  = 14;
    localparam int unsigned KEY_DIV = 15;

    // All rows released (rows are driven active-low)
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Active-low one-hot drive pattern for the given row index
    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        row_drive = ROW_IDLE ^ (4'b0001 << idx);
    endfunction

    // Number of set bits in a 16-bit key map
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        popcount16 = cnt;
    endfunction

endpackage

// File: rtl/key_frame_debounce.sv
// Whole-frame debouncer for the keypad scanner. A frame must repeat
// DEBOUNCE_SCANS times in a row before it is committed to key_out; the
// commit happens on the cycle after the frame that completes the run.
// Optional build macro: KEY_SINGLE_PRESS_EN (suppress press pulses unless the
// committed frame holds exactly one key).
module key_frame_debounce
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic [15:0] frame,
    output logic [15:0] key_out,
    output logic [15:0] key_pulse
);

    localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS);

    logic [15:0] prev_r;
    logic [3:0]  stable_r;
    logic        commit_pend_r;
    logic [15:0] key_out_r;
    logic [15:0] key_pulse_r;

    logic [3:0]  stable_next_s;
    logic        commit_s;
    logic [15:0] rise_s;
    logic [15:0] pulse_next_s;

    // Next stable count and commit decision; prev_r already holds the frame
    // that just completed when commit_pend_r is set.
    always_comb begin
        stable_next_s = 4'd1;
        commit_s      = 1'b0;
        rise_s        = prev_r & ~key_out_r;
        pulse_next_s  = 16'h0000;

        if (frame == prev_r) begin
            if (stable_r >= STABLE_MAX) begin
                stable_next_s = STABLE_MAX;
            end else begin
                stable_next_s = stable_r + 4'd1;
            end
        end else begin
            stable_next_s = 4'd1;
        end

        if (commit_pend_r && (stable_r == STABLE_MAX) && (prev_r != key_out_r)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end

        if (commit_s) begin
`ifdef KEY_SINGLE_PRESS_EN
            if (popcount16(prev_r) == 5'd1) begin
                pulse_next_s = rise_s;
            end else begin
                pulse_next_s = 16'h0000;
            end
`else
            pulse_next_s = rise_s;
`endif
        end else begin
            pulse_next_s = 16'h0000;
        end
    end

    // Frame history, stable count and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r        <= 16'h0000;
            stable_r      <= 4'd0;
            commit_pend_r <= 1'b0;
            key_out_r     <= 16'h0000;
            key_pulse_r   <= 16'h0000;
        end else begin
            if (frame_valid) begin
                prev_r   <= frame;
                stable_r <= stable_next_s;
            end
            commit_pend_r <= frame_valid;
            key_pulse_r   <= pulse_next_s;
            if (commit_s) begin
                key_out_r <= prev_r;
            end
        end
    end

    assign key_out   = key_out_r;
    assign key_pulse = key_pulse_r;

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 calculator keypad scanner: drives one row at a time (active low),
// samples the columns at the end of each row dwell, assembles full-matrix
// frames and hands them to key_frame_debounce.
// Optional build macro: KEY_SINGLE_PRESS_EN (see key_frame_debounce).
module key_matrix_scan
    import calc_pkg::*;
#(
    parameter int unsigned NUM_FOR_SCAN   = 60000,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] key_out,
    output logic [15:0] key_pulse
);

    localparam int unsigned      CNT_W    = $clog2(NUM_FOR_SCAN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FOR_SCAN - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       row_idx_r;
    logic [3:0]       row_r;
    // Rows 0..2 only: the row-3 columns go straight into the completed frame
    logic [11:0]      raw_r;

    logic             dwell_end_s;
    logic             frame_valid_s;
    logic [15:0]      frame_s;

    // End-of-dwell strobe and frame assembly
    always_comb begin
        dwell_end_s   = (cnt_r == CNT_LAST);
        frame_valid_s = dwell_end_s && (row_idx_r == 2'd3);
        frame_s       = {~col, raw_r};
    end

    // Dwell counter, row sequencing and column capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            row_idx_r <= 2'd0;
            row_r     <= row_drive(2'd0);
            raw_r     <= 12'h000;
        end else if (dwell_end_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            row_idx_r <= row_idx_r + 2'd1;
            row_r     <= row_drive(row_idx_r + 2'd1);
            case (row_idx_r)
                2'd0:    raw_r[3:0]  <= ~col;
                2'd1:    raw_r[7:4]  <= ~col;
                2'd2:    raw_r[11:8] <= ~col;
                default: raw_r       <= raw_r;
            endcase
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign row = row_r;

    key_frame_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid_s),
        .frame       (frame_s),
        .key_out     (key_out),
        .key_pulse   (key_pulse)
    );

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan with NUM_FOR_SCAN=4, DEBOUNCE_SCANS=3
// (one frame = 16 cycles). A keypad model closes column lines according to
// the currently driven row and the set of pressed keys.
module tb_key_matrix_scan;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_out;
    logic [15:0] key_pulse;

    logic [15:0] pressed;
    logic        col_force;
    logic [3:0]  cols_s;

    int errors;
    int checks;
    int edge_n;

    key_matrix_scan #(
        .NUM_FOR_SCAN   (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key_out   (key_out),
        .key_pulse (key_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its column low while its row is driven
    always_comb begin
        cols_s = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (row[r] == 1'b0) cols_s = cols_s | pressed[r*4 +: 4];
        end
    end
    assign col = col_force ? 4'b0000 : ~cols_s;

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic align();
        while (edge_n % 16 != 0) step();
    endtask

    // Run n cycles and require that no press pulse appears
    task automatic quiet(input string tag, input int n);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (key_pulse !== 16'h0000) hits++;
        end
        check(tag, 16'(hits), 16'h0000);
    endtask

    // Wait (bounded) for the first pulse; check its latency, value, key_out
    // and that it lasts exactly one cycle
    task automatic wait_pulse(input string tag, input logic [15:0] exp_pulse,
                              input logic [15:0] exp_out, input int exp_lat);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        while (!found && n < exp_lat + 16) begin
            step();
            n++;
            if (key_pulse !== 16'h0000) found = 1'b1;
        end
        check({tag, "_latency"}, 16'(n), 16'(exp_lat));
        check({tag, "_pulse"}, key_pulse, exp_pulse);
        check({tag, "_key_out"}, key_out, exp_out);
        step();
        check({tag, "_pulse_end"}, key_pulse, 16'h0000);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        edge_n    = 0;
        pressed   = 16'h0000;
        col_force = 1'b1;
        rst_n     = 1'b0;

        // 1. Reset held 5 cycles with all columns low
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_row", {12'h000, row}, 16'h000E);
            check("rst_key_out", key_out, 16'h0000);
            check("rst_key_pulse", key_pulse, 16'h0000);
        end
        rst_n     = 1'b1;
        col_force = 1'b0;
        edge_n    = 0;
        step(); step(); step();
        check("row_hold_3", {12'h000, row}, 16'h000E);
        step();
        check("row_first_change", {12'h000, row}, 16'h000D);
        quiet("idle_no_pulse", 60);
        check("idle_key_out", key_out, 16'h0000);

        // 2. Clean press of '6' (row 1 / col 2) from frame start
        align();
        pressed = 16'h0040;
        wait_pulse("press6", 16'h0040, 16'h0040, 49);
        pressed = 16'h0000;
        quiet("release6_no_pulse", 64);
        check("release6_key_out", key_out, 16'h0000);

        // 3. '=' bouncing every frame for 5 frames, then held
        align();
        for (int f = 0; f < 5; f++) begin
            pressed = (f % 2 == 1) ? 16'h4000 : 16'h0000;
            quiet("bounce_no_pulse", 16);
        end
        check("bounce_key_out", key_out, 16'h0000);
        pressed = 16'h4000;
        wait_pulse("eq_hold", 16'h4000, 16'h4000, 49);
        pressed = 16'h0000;
        quiet("release_eq_no_pulse", 64);
        check("release_eq_key_out", key_out, 16'h0000);

        // 4. '1' and '+' in the same frame
        align();
        pressed = 16'h0009;
`ifdef KEY_SINGLE_PRESS_EN
        quiet("two_keys_gated", 49);
        check("two_keys_key_out", key_out, 16'h0009);
`else
        wait_pulse("two_keys", 16'h0009, 16'h0009, 49);
`endif
        pressed = 16'h0000;
        quiet("release_two_no_pulse", 64);
        check("release_two_key_out", key_out, 16'h0000);

        // 5. Reset during the row-2 dwell while 'C' is held
        align();
        pressed = 16'h2000;
        wait_pulse("clr_first", 16'h2000, 16'h2000, 49);
        align();
        for (int i = 0; i < 9; i++) step();
        check("mid_row2_drive", {12'h000, row}, 16'h000B);
        rst_n = 1'b0;
        step(); step();
        check("mid_rst_key_out", key_out, 16'h0000);
        check("mid_rst_row", {12'h000, row}, 16'h000E);
        check("mid_rst_pulse", key_pulse, 16'h0000);
        rst_n  = 1'b1;
        edge_n = 0;
        wait_pulse("clr_recommit", 16'h2000, 16'h2000, 49);
        pressed = 16'h0000;
        quiet("release_clr_no_pulse", 64);
        check("release_clr_key_out", key_out, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
